// File: rtl/upl_pkg.sv
// Shared UPL definitions: word geometry, report layout, FSM states and small helpers.
package upl_pkg;

   localparam int unsigned UPL_W         = 32;
   localparam int unsigned UPL_WORDS     = 8;
   localparam int unsigned UPL_IDX_W     = 3;
   localparam int unsigned UPL_HDR_WORDS = 4;
   localparam int unsigned UPL_CNT_W     = 16;

   localparam logic [UPL_W-1:0] UPL_MAGIC_DEFAULT = 32'h5354_4154;
   localparam logic [15:0]      UPL_UDP_LEN       = 16'd16;

   localparam logic [UPL_IDX_W-1:0] IDX_MY_IP  = 3'd0;
   localparam logic [UPL_IDX_W-1:0] IDX_DST_IP = 3'd1;
   localparam logic [UPL_IDX_W-1:0] IDX_PORTS  = 3'd2;
   localparam logic [UPL_IDX_W-1:0] IDX_LEN    = 3'd3;
   localparam logic [UPL_IDX_W-1:0] IDX_SEQ    = 3'd4;
   localparam logic [UPL_IDX_W-1:0] IDX_TS     = 3'd5;
   localparam logic [UPL_IDX_W-1:0] IDX_STATUS = 3'd6;
   localparam logic [UPL_IDX_W-1:0] IDX_MAGIC  = 3'd7;

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_HDR, ST_PAY} upl_state_e;

   typedef logic [UPL_WORDS-1:0][UPL_W-1:0] upl_words_t;

   typedef struct packed {
      logic [UPL_W-1:0] src_ip;
      logic [UPL_W-1:0] dst_ip;
      logic [15:0]      src_port;
      logic [15:0]      dst_port;
      logic [UPL_W-1:0] seq;
      logic [UPL_W-1:0] ts;
      logic [UPL_W-1:0] status;
      logic [UPL_W-1:0] magic;
   } upl_report_s;

   // Lay a report out in wire order, word 0 first.
   function automatic upl_words_t upl_pack(input upl_report_s r);
      upl_words_t w;
      w             = '0;
      w[IDX_MY_IP]  = r.src_ip;
      w[IDX_DST_IP] = r.dst_ip;
      w[IDX_PORTS]  = {r.src_port, r.dst_port};
      w[IDX_LEN]    = {UPL_UDP_LEN, 16'h0000};
      w[IDX_SEQ]    = r.seq;
      w[IDX_TS]     = r.ts;
      w[IDX_STATUS] = r.status;
      w[IDX_MAGIC]  = r.magic;
      return w;
   endfunction

   // Saturating add of a small increment onto a 16-bit counter.
   function automatic logic [UPL_CNT_W-1:0] upl_sat_add(input logic [UPL_CNT_W-1:0] a,
                                                        input logic [1:0]           b);
      logic [UPL_CNT_W:0] s;
      s = (UPL_CNT_W+1)'(a) + (UPL_CNT_W+1)'(b);
      return s[UPL_CNT_W] ? {UPL_CNT_W{1'b1}} : s[UPL_CNT_W-1:0];
   endfunction

endpackage

// File: rtl/upl_word_mux.sv
// 8:1 selection of the outgoing report word by index.
module upl_word_mux
   import upl_pkg::*;
(
   input  upl_words_t             words,
   input  logic [UPL_IDX_W-1:0]   idx,
   output logic [UPL_W-1:0]       word_c
);

   assign word_c = words[idx];

endmodule

// File: rtl/upl_status_tx.sv
// UPL report source: periodic/on-demand status packets over a UDP send port,
// with request/grant handshake, one-deep pending trigger and drop accounting.
module upl_status_tx
   import upl_pkg::*;
#(
   parameter int unsigned      PERIOD      = 125_000_000,
   parameter int unsigned      ACK_TIMEOUT = 1024,
   parameter logic [UPL_W-1:0] MAGIC       = UPL_MAGIC_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic                 send_now,
   input  logic [UPL_W-1:0]     status_in,
   input  logic [UPL_W-1:0]     my_ip,
   input  logic [UPL_W-1:0]     dst_ip,
   input  logic [15:0]          src_port,
   input  logic [15:0]          dst_port,
   output logic [UPL_W-1:0]     UPL_output_data,
   output logic                 UPL_output_en,
   output logic                 UPL_output_req,
   input  logic                 UPL_output_ack,
   output logic                 busy,
   output logic [UPL_CNT_W-1:0] sent_count,
   output logic [UPL_CNT_W-1:0] drop_count
);

   localparam int unsigned TMR_W = 32;
   localparam int unsigned TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   upl_state_e           state_q, state_d;
   logic [UPL_IDX_W-1:0] idx_q, idx_d, mux_idx;
   logic [TO_W-1:0]      wait_q, wait_d;
   logic [TMR_W-1:0]     timer_q, timer_d;
   logic [UPL_W-1:0]     ts_q, seq_q, seq_d, tsl_q, tsl_d, stat_q, stat_d;
   logic                 pend_q, pend_d;
   logic                 req_d, en_d;
   logic [UPL_W-1:0]     data_d, mux_word;
   logic [UPL_CNT_W-1:0] sent_d, drop_d;
   logic [1:0]           drop_inc;
   logic                 timer_tc, trig;
   upl_report_s          rpt;

   assign timer_tc = enable && (PERIOD != 0) && (timer_q == TMR_W'(PERIOD - 1));
   assign trig     = send_now | timer_tc;

   always_comb begin
      rpt = '{src_ip: my_ip, dst_ip: dst_ip, src_port: src_port, dst_port: dst_port,
              seq: seq_q, ts: tsl_q, status: stat_q, magic: MAGIC};
   end

   // Word launched at the next edge: word 0 on grant, otherwise the following index.
   always_comb begin
      mux_idx = (state_q == ST_REQ) ? IDX_MY_IP : idx_q + 3'd1;
   end

   upl_word_mux u_word_mux (
      .words  (upl_pack(rpt)),
      .idx    (mux_idx),
      .word_c (mux_word)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      wait_d   = wait_q;
      pend_d   = pend_q;
      seq_d    = seq_q;
      sent_d   = sent_count;
      tsl_d    = tsl_q;
      stat_d   = stat_q;
      req_d    = 1'b0;
      en_d     = 1'b0;
      data_d   = '0;
      drop_inc = 2'd0;
      timer_d  = (!enable || timer_tc) ? '0 : timer_q + 32'd1;

      unique case (state_q)
         ST_IDLE: begin
            // A trigger arriving together with a pending one merges into this packet.
            if (trig || pend_q) begin
               state_d = ST_REQ;
               req_d   = 1'b1;
               wait_d  = '0;
               pend_d  = 1'b0;
               stat_d  = status_in;
               tsl_d   = ts_q;
            end
         end
         ST_REQ: begin
            if (UPL_output_ack) begin
               state_d = ST_HDR;
               idx_d   = IDX_MY_IP;
               en_d    = 1'b1;
               data_d  = mux_word;
            end else if (wait_q == TO_W'(ACK_TIMEOUT - 1)) begin
               state_d  = ST_IDLE;
               drop_inc = drop_inc + 2'd1;
            end else begin
               wait_d = wait_q + 1'b1;
               req_d  = 1'b1;
            end
         end
         ST_HDR, ST_PAY: begin
            if (idx_q == IDX_MAGIC) begin
               state_d = ST_IDLE;
               seq_d   = seq_q + 32'd1;
               sent_d  = sent_count + 16'd1;
            end else begin
               idx_d   = idx_q + 3'd1;
               en_d    = 1'b1;
               data_d  = mux_word;
               state_d = (idx_q + 3'd1 >= UPL_IDX_W'(UPL_HDR_WORDS)) ? ST_PAY : ST_HDR;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (trig && state_q != ST_IDLE) begin
         if (pend_q) drop_inc = drop_inc + 2'd1;
         else        pend_d   = 1'b1;
      end

      drop_d = upl_sat_add(drop_count, drop_inc);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= ST_IDLE;
         idx_q           <= '0;
         wait_q          <= '0;
         timer_q         <= '0;
         ts_q            <= '0;
         seq_q           <= '0;
         tsl_q           <= '0;
         stat_q          <= '0;
         pend_q          <= 1'b0;
         UPL_output_req  <= 1'b0;
         UPL_output_en   <= 1'b0;
         UPL_output_data <= '0;
         busy            <= 1'b0;
         sent_count      <= '0;
         drop_count      <= '0;
      end else begin
         state_q         <= state_d;
         idx_q           <= idx_d;
         wait_q          <= wait_d;
         timer_q         <= timer_d;
         ts_q            <= ts_q + 32'd1;
         seq_q           <= seq_d;
         tsl_q           <= tsl_d;
         stat_q          <= stat_d;
         pend_q          <= pend_d;
         UPL_output_req  <= req_d;
         UPL_output_en   <= en_d;
         UPL_output_data <= data_d;
         busy            <= (state_d != ST_IDLE);
         sent_count      <= sent_d;
         drop_count      <= drop_d;
      end
   end

endmodule

// File: tb/tb_upl_status_tx.sv
// Bench for upl_status_tx: directed vectors, corner sequences and a randomized
// run against a schedule-based reference model.
module tb_upl_status_tx;

   localparam int          TO    = 16;
   localparam logic [31:0] MAGIC = 32'h5354_4154;

   logic        clk;
   logic        reset_n;
   logic        enable, send_now, ack;
   logic [31:0] status_in, my_ip, dst_ip;
   logic [15:0] src_port, dst_port;
   logic [31:0] data;
   logic        en, req, busy;
   logic [15:0] sent_count, drop_count;

   int n_pass, n_total;
   int cyc;

   upl_status_tx #(.PERIOD(100), .ACK_TIMEOUT(TO), .MAGIC(MAGIC)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .send_now(send_now),
      .status_in(status_in), .my_ip(my_ip), .dst_ip(dst_ip),
      .src_port(src_port), .dst_port(dst_port),
      .UPL_output_data(data), .UPL_output_en(en), .UPL_output_req(req),
      .UPL_output_ack(ack), .busy(busy),
      .sent_count(sent_count), .drop_count(drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edges since reset release; equals the DUT timestamp latched at the next edge.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   typedef struct {
      logic [31:0]      my_ip, dst_ip;
      logic [15:0]      sp, dp;
      logic [31:0]      status;
      int               dly;
      logic [7:0][31:0] exp;
   } vec_t;

   vec_t vecs[3];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
      else n_pass++;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; enable = 1'b0; send_now = 1'b0; ack = 1'b0; status_in = '0;
      @(negedge clk); @(negedge clk);
      reset_n = 1'b1;
   endtask

   // One packet triggered by send_now, granted dly cycles after req is seen.
   task automatic send_pkt(input vec_t v, input logic [31:0] exp_seq);
      logic [7:0][31:0] e;
      int t0;
      e = v.exp;
      my_ip = v.my_ip; dst_ip = v.dst_ip; src_port = v.sp; dst_port = v.dp;
      status_in = v.status; send_now = 1'b1; t0 = cyc;
      e[4] = exp_seq; e[5] = 32'(t0);
      @(negedge clk);
      send_now = 1'b0; status_in = ~v.status;
      chk("req_latency", req, 1'b1);
      repeat (v.dly) @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      chk("req_drop_on_grant", req, 1'b0);
      for (int w = 0; w < 8; w++) begin
         chk($sformatf("en_w%0d", w), en, 1'b1);
         chk($sformatf("data_w%0d", w), data, e[w]);
         if (w < 7) @(negedge clk);
      end
      @(negedge clk);
      chk("en_after", en, 1'b0);
      chk("data_after", data, 32'h0);
      chk("busy_after", busy, 1'b0);
   endtask

   // Packet with three send_now pulses inside it, then the pending packet.
   task automatic pulses_pkt(input logic [31:0] seq0);
      send_now = 1'b1;
      @(negedge clk);
      send_now = 1'b0;
      chk("p_req", req, 1'b1);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("p_en", en, 1'b1);
         if (i == 4) chk("p_seq0", data, seq0);
         send_now = (i == 1 || i == 3 || i == 5);
         @(negedge clk);
      end
      send_now = 1'b0;
      chk("p_idle_en", en, 1'b0);
      chk("p_idle_req", req, 1'b0);
      chk("p_idle_busy", busy, 1'b0);
      @(negedge clk);
      chk("p_pending_req", req, 1'b1);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("p2_en", en, 1'b1);
         if (i == 4) chk("p2_seq", data, seq0 + 32'd1);
         @(negedge clk);
      end
      chk("p2_end_en", en, 1'b0);
   endtask

   logic [31:0]      pw[32];
   int               pn, rq_cnt;
   logic [7:0][31:0] exp_q[$];
   logic [7:0][31:0] got, expw;
   int               gi;
   int               m_idle_from, m_ack_edge, m_req_first, m_req_last, m_sent, m_drop;
   bit               m_pend;
   logic [31:0]      m_seq;

   initial begin
      n_pass = 0; n_total = 0;
      my_ip = '0; dst_ip = '0; src_port = '0; dst_port = '0;
      vecs[0] = '{32'h0a000003, 32'h0a000001, 16'h4000, 16'h4000, 32'h1234_5678, 2,
                  {MAGIC, 32'h1234_5678, 32'h0, 32'h0, 32'h0010_0000, 32'h4000_4000,
                   32'h0a00_0001, 32'h0a00_0003}};
      vecs[1] = '{32'hc0a80001, 32'hc0a800ff, 16'h1234, 16'habcd, 32'hdead_beef, 0,
                  {MAGIC, 32'hdead_beef, 32'h0, 32'h0, 32'h0010_0000, 32'h1234_abcd,
                   32'hc0a8_00ff, 32'hc0a8_0001}};
      vecs[2] = '{32'hffffffff, 32'h00000000, 16'hffff, 16'h0001, 32'h0, TO - 1,
                  {MAGIC, 32'h0, 32'h0, 32'h0, 32'h0010_0000, 32'hffff_0001,
                   32'h0000_0000, 32'hffff_ffff}};

      // Reset state and directed packets.
      do_reset();
      chk("rst_req", req, 1'b0);
      chk("rst_en", en, 1'b0);
      chk("rst_data", data, 32'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_sent", sent_count, 16'h0);
      chk("rst_drop", drop_count, 16'h0);
      for (int k = 0; k < 3; k++) begin
         send_pkt(vecs[k], 32'(k));
         chk("sent_cnt", sent_count, 16'(k + 1));
      end
      chk("vec_drop", drop_count, 16'h0);

      // Periodic reports, immediate grant.
      do_reset();
      enable = 1'b1; pn = 0; rq_cnt = cyc;
      for (int i = 0; i < 350; i++) begin
         @(negedge clk);
         if (en && pn < 32) begin pw[pn] = data; pn++; end
         ack = req;
      end
      enable = 1'b0; ack = 1'b0;
      chk("per_words", 32'(pn), 32'd24);
      for (int p = 0; p < 3; p++) begin
         chk("per_seq", pw[p*8+4], 32'(p));
         chk("per_ts", pw[p*8+5], 32'(rq_cnt + 99 + 100*p));
         chk("per_magic", pw[p*8+7], MAGIC);
      end
      chk("per_ts_diff", pw[13] - pw[5], 32'd100);
      chk("per_sent", sent_count, 16'd3);

      // Grant never arrives.
      do_reset();
      send_now = 1'b1;
      rq_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         send_now = 1'b0;
         if (req) rq_cnt++;
         else if (rq_cnt > 0) break;
      end
      chk("to_req_cycles", 32'(rq_cnt), 32'(TO));
      chk("to_drop", drop_count, 16'd1);
      chk("to_busy", busy, 1'b0);
      chk("to_sent", sent_count, 16'd0);
      send_pkt(vecs[1], 32'd0);

      // Overrun during a packet.
      do_reset();
      pulses_pkt(32'd0);
      chk("ovr_drop", drop_count, 16'd2);
      chk("ovr_sent", sent_count, 16'd2);

      // Reset during PAY word 5.
      do_reset();
      send_now = 1'b1;
      @(negedge clk);
      send_now = 1'b0; ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      repeat (5) @(negedge clk);
      chk("mid_en_before", en, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("mid_req", req, 1'b0);
      chk("mid_en", en, 1'b0);
      chk("mid_data", data, 32'h0);
      chk("mid_busy", busy, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      send_pkt(vecs[0], 32'd0);
      chk("mid_sent", sent_count, 16'd1);

      // Counter wrap and saturation.
      do_reset();
      force dut.sent_count = 16'hFFFF;
      #1;
      release dut.sent_count;
      send_pkt(vecs[2], 32'd0);
      chk("sent_wrap", sent_count, 16'h0);
      force dut.drop_count = 16'hFFFE;
      #1;
      release dut.drop_count;
      pulses_pkt(32'd1);
      chk("drop_sat", drop_count, 16'hFFFF);

      // Randomized run against the schedule model.
      do_reset();
      my_ip = $urandom; dst_ip = $urandom; src_port = 16'($urandom); dst_port = 16'($urandom);
      m_idle_from = 0; m_ack_edge = -1; m_req_first = 1; m_req_last = 0;
      m_sent = 0; m_drop = 0; m_pend = 0; m_seq = '0; gi = 0;
      exp_q.delete();
      for (int c = 0; c < 1600; c++) begin
         chk("rnd_req", req, (c >= m_req_first && c <= m_req_last));
         if (en) begin
            got[gi] = data; gi++;
            if (gi == 8) begin
               gi = 0;
               chk("rnd_pkt_avail", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  expw = exp_q.pop_front();
                  for (int w = 0; w < 8; w++) chk($sformatf("rnd_w%0d", w), got[w], expw[w]);
               end
            end
         end else begin
            chk("rnd_data_idle", data, 32'h0);
         end
         send_now  = (c < 1500) && ($urandom_range(0, 11) == 0);
         status_in = $urandom;
         ack = (c == m_ack_edge) ||
               (m_ack_edge >= 0 && c > m_ack_edge && c < m_idle_from && $urandom_range(0, 1) == 1);
         if (c >= m_idle_from) begin
            if (send_now || m_pend) begin
               int r, d;
               m_pend = 0;
               r = int'($urandom_range(0, 9));
               d = (r < 6) ? int'($urandom_range(0, 4)) : (r < 8) ? TO - 1 : (r == 8) ? TO : TO + 4;
               m_req_first = c + 1;
               if (d < TO) begin
                  m_ack_edge  = c + 1 + d;
                  m_req_last  = m_ack_edge;
                  m_idle_from = m_ack_edge + 9;
                  exp_q.push_back({MAGIC, status_in, 32'(c), m_seq, 32'h0010_0000,
                                   {src_port, dst_port}, dst_ip, my_ip});
                  m_seq++; m_sent++;
               end else begin
                  m_ack_edge  = -1;
                  m_req_last  = c + TO;
                  m_idle_from = c + TO + 1;
                  m_drop++;
               end
            end
         end else if (send_now) begin
            if (m_pend) m_drop++;
            else        m_pend = 1;
         end
         @(negedge clk);
      end
      send_now = 1'b0; ack = 1'b0;
      chk("rnd_sent", sent_count, 16'(m_sent));
      chk("rnd_drop", drop_count, 16'(m_drop));
      chk("rnd_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("rnd_partial", 32'(gi), 32'd0);
      chk("rnd_busy", busy, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
